// File: rtl/freq_count_pkg.sv
// Shared constants for the frequency_counter register map and the measurement master FSM.
// frequency_counter uses the address/control constants for its own decode.
package freq_count_pkg;

  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0008;
  localparam logic [31:0] ADDR_RESULT = 32'h0000_0009;
  localparam logic [31:0] CTRL_RST    = 32'h0000_0001;
  localparam logic [31:0] CTRL_START  = 32'h0000_0080;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_RST   = 3'd1;
  localparam logic [2:0] S_GAP1     = 3'd2;
  localparam logic [2:0] S_WR_START = 3'd3;
  localparam logic [2:0] S_GATE     = 3'd4;
  localparam logic [2:0] S_RD_RES   = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  // Counter width able to hold 0..n without wrapping; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic transfer with response timeout and bounded retry.
// Emits a one-cycle ok or fail strobe in the cycle the outcome is sampled.
module wb_single_xfer
  import freq_count_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        ok,
  output logic        fail,
  output logic [31:0] rdata,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  output logic        cyc_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int TW = cnt_w(ACK_TIMEOUT);
  localparam int RW = cnt_w(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  logic          cyc_q;
  logic          regap_q;
  logic [TW-1:0] tmo_q;
  logic [RW-1:0] rty_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic          we_q;
  logic          any_resp;
  logic          timeout;
  logic          retry;

  // err beats rty beats ack when several arrive together.
  assign any_resp = ack_i | err_i | rty_i;
  assign timeout  = cyc_q & ~any_resp & (tmo_q == TMO_LAST);
  assign retry    = cyc_q & ~err_i & rty_i & (rty_q != RTY_MAX);
  assign fail     = (cyc_q & (err_i | (rty_i & (rty_q == RTY_MAX)))) | timeout;
  assign ok       = cyc_q & ack_i & ~err_i & ~rty_i;
  assign rdata    = dat_i;

  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign we_o  = we_q;
  assign cyc_o = cyc_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= 1'b0;
      regap_q <= 1'b0;
      tmo_q   <= '0;
      rty_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
    end else if (req && !cyc_q && !regap_q) begin
      cyc_q <= 1'b1;
      adr_q <= adr;
      dat_q <= dat;
      we_q  <= we;
      tmo_q <= '0;
      rty_q <= '0;
    end else if (cyc_q) begin
      if (any_resp) begin
        cyc_q <= 1'b0;
        if (retry) begin
          regap_q <= 1'b1;
          rty_q   <= rty_q + 1'b1;
        end
      end else if (timeout) begin
        cyc_q <= 1'b0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end else if (regap_q) begin
      // Reissue the held transfer after the one-cycle retry gap.
      cyc_q   <= 1'b1;
      regap_q <= 1'b0;
      tmo_q   <= '0;
    end
  end

endmodule

// File: rtl/freq_count_wb_master.sv
// Wishbone initiator that runs one frequency_counter measurement per start_i pulse:
// reset counter, start it, wait the gate time, read the result.
//
// state      | meaning
// S_IDLE     | waiting for start_i; issues the counter-reset write when it arrives
// S_WR_RST   | counter-reset write in flight
// S_GAP1     | bus idle cycle; issues the start write
// S_WR_START | start write in flight
// S_GATE     | gate down-counter running; issues the result read at zero
// S_RD_RES   | result read in flight
// S_DONE     | success, done_o pulse
// S_ERR      | bus failure, done_o pulse with error_o set
module freq_count_wb_master
  import freq_count_pkg::*;
#(
  parameter int GATE_CYCLES = 90,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] result_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int GW = cnt_w(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

  logic [2:0]    state_q;
  logic [GW-1:0] gate_q;
  logic          error_q;
  logic [31:0]   result_q;

  logic          req;
  logic          req_we;
  logic [31:0]   req_adr;
  logic [31:0]   req_dat;
  logic          xfer_ok;
  logic          xfer_fail;
  logic [31:0]   xfer_rdata;
  logic          xfer_we;
  logic          xfer_cyc;

  always_comb begin
    req     = 1'b0;
    req_we  = 1'b1;
    req_adr = ADDR_CTRL;
    req_dat = CTRL_RST;
    case (state_q)
      S_IDLE: req = start_i;
      S_GAP1: begin
        req     = 1'b1;
        req_dat = CTRL_START;
      end
      S_GATE: begin
        req     = (gate_q == '0);
        req_we  = 1'b0;
        req_adr = ADDR_RESULT;
        req_dat = '0;
      end
      default: req = 1'b0;
    endcase
  end

  wb_single_xfer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) u_xfer (
    .clk_i(clk_i),
    .rst_n(rst_i),
    .req  (req),
    .we   (req_we),
    .adr  (req_adr),
    .dat  (req_dat),
    .ok   (xfer_ok),
    .fail (xfer_fail),
    .rdata(xfer_rdata),
    .adr_o(adr_o),
    .dat_o(dat_o),
    .we_o (xfer_we),
    .cyc_o(xfer_cyc),
    .dat_i(dat_i),
    .ack_i(ack_i),
    .err_i(err_i),
    .rty_i(rty_i)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      gate_q   <= '0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_WR_RST;
            error_q <= 1'b0;
          end
        end
        S_WR_RST: begin
          if (xfer_fail) begin
            state_q <= S_ERR;
            error_q <= 1'b1;
          end else if (xfer_ok) begin
            state_q <= S_GAP1;
          end
        end
        S_GAP1: state_q <= S_WR_START;
        S_WR_START: begin
          if (xfer_fail) begin
            state_q <= S_ERR;
            error_q <= 1'b1;
          end else if (xfer_ok) begin
            state_q <= S_GATE;
            gate_q  <= GATE_LOAD;
          end
        end
        S_GATE: begin
          if (gate_q == '0) begin
            state_q <= S_RD_RES;
          end else begin
            gate_q <= gate_q - 1'b1;
          end
        end
        S_RD_RES: begin
          if (xfer_fail) begin
            state_q <= S_ERR;
            error_q <= 1'b1;
          end else if (xfer_ok) begin
            state_q  <= S_DONE;
            result_q <= xfer_rdata;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE) || (state_q == S_ERR);
  assign error_o  = error_q;
  assign result_o = result_q;
  assign cyc_o    = xfer_cyc;
  assign stb_o    = xfer_cyc;
  assign we_o     = xfer_we & xfer_cyc;
  assign sel_o    = {4{xfer_cyc}};

endmodule
